// File: rtl/ibex_fetch_fifo_wide_if.sv
// Fetch FIFO handshake bundle: aligned fetch beats in,
// realigned instructions out.
interface ibex_fetch_fifo_wide_if #(
  parameter int BusBytes = 4
);
  logic                  in_valid_i;
  logic [31:0]           in_addr_i;
  logic [BusBytes*8-1:0] in_rdata_i;
  logic                  in_err_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [31:0]           out_addr_o;
  logic [31:0]           out_rdata_o;
  logic                  out_err_o;
  logic                  out_err_plus2_o;

  modport master (
    output in_valid_i,
    output in_addr_i,
    output in_rdata_i,
    output in_err_i,
    output out_ready_i,
    input  out_valid_o,
    input  out_addr_o,
    input  out_rdata_o,
    input  out_err_o,
    input  out_err_plus2_o
  );

  modport slave (
    input  in_valid_i,
    input  in_addr_i,
    input  in_rdata_i,
    input  in_err_i,
    input  out_ready_i,
    output out_valid_o,
    output out_addr_o,
    output out_rdata_o,
    output out_err_o,
    output out_err_plus2_o
  );
endinterface

// File: rtl/ibex_fetch_fifo_wide.sv
// Wide instruction fetch FIFO: buffers 32/64-bit fetch beats
// and realigns them into 16/32-bit instructions for IF.
module ibex_fetch_fifo_wide #(
  parameter int NumReqs  = 2,
  parameter int BusBytes = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  output logic [NumReqs-1:0]            busy_o,
  output logic [$clog2(NumReqs+2)-1:0]  count_o,
  ibex_fetch_fifo_wide_if.slave         bus
);

  localparam int Depth = NumReqs + 1;
  localparam int BusW  = BusBytes * 8;
  localparam int NumHw = BusBytes / 2;
  localparam int HwW   = $clog2(BusBytes) - 1;
  localparam int CntW  = $clog2(Depth + 1);
  localparam logic [HwW-1:0] HwLast = HwW'(NumHw - 1);
  localparam logic [HwW-1:0] HwPen  = HwW'(NumHw - 2);

  if (BusBytes != 4 && BusBytes != 8) begin : g_bad_bus
    $error("ibex_fetch_fifo_wide: BusBytes must be 4 or 8");
  end

  logic [BusW-1:0]  data_q [Depth];
  logic [BusW-1:0]  data_d [Depth];
  logic [Depth-1:0] err_q, err_d;
  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] wr;
  logic [31:1]      addr_q;
  logic [CntW-1:0]  count_q, cnt_d;

  logic [HwW-1:0]  hw, hw_nxt;
  logic [BusW-1:0] head_data, next_data;
  logic            head_err, next_err;
  logic [15:0]     h0, h1;
  logic            spanning, compressed, span32;
  logic            xfer, pop, pop_entry, push;
  logic            unused_addr0;

  assign unused_addr0 = bus.in_addr_i[0];

  assign hw     = addr_q[HwW:1];
  assign hw_nxt = hw + HwW'(1);

  // Empty slots fall through to the incoming beat (bypass).
  assign head_data = valid_q[0] ? data_q[0] : bus.in_rdata_i;
  assign head_err  = valid_q[0] ? err_q[0]  : bus.in_err_i;
  assign next_data = valid_q[1] ? data_q[1] : bus.in_rdata_i;
  assign next_err  = valid_q[1] ? err_q[1]  : bus.in_err_i;

  assign spanning   = (hw == HwLast);
  assign h0         = head_data[{hw, 4'b0000} +: 16];
  assign h1         = spanning ? next_data[15:0]
                               : head_data[{hw_nxt, 4'b0000} +: 16];
  assign compressed = (h0[1:0] != 2'b11) & ~head_err;
  assign span32     = spanning & ~compressed;

  assign bus.out_valid_o =
    span32 ? (valid_q[1] | (valid_q[0] & bus.in_valid_i))
           : (valid_q[0] | bus.in_valid_i);
  assign bus.out_err_o       = head_err | (span32 & next_err);
  assign bus.out_err_plus2_o = span32 & next_err & ~head_err;
  assign bus.out_rdata_o     = {h1, h0};
  assign bus.out_addr_o      = {addr_q, 1'b0};

  assign xfer = bus.out_valid_o & bus.out_ready_i & ~clear_i;
  assign pop  = xfer & (spanning | ((hw == HwPen) & ~compressed));

  // A bypassed beat that is fully consumed is never stored.
  assign pop_entry = pop & valid_q[0];
  assign push      = bus.in_valid_i & ~clear_i & ~(pop & ~valid_q[0]);

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    if (pop_entry) begin
      valid_d = valid_q >> 1;
      err_d   = err_q >> 1;
      for (int i = 0; i < Depth - 1; i++) begin
        data_d[i] = data_q[i+1];
      end
    end
    // One-hot lowest free slot; all-zero when full drops the beat.
    wr = ~valid_d & (valid_d + Depth'(1));
    for (int i = 0; i < Depth; i++) begin
      if (push && wr[i]) begin
        data_d[i]  = bus.in_rdata_i;
        err_d[i]   = bus.in_err_i;
        valid_d[i] = 1'b1;
      end
    end
    if (clear_i) begin
      valid_d = '0;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < Depth; i++) begin
      cnt_d = cnt_d + CntW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      count_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= cnt_d;
      if (clear_i) begin
        addr_q <= bus.in_addr_i[31:1];
      end else if (xfer) begin
        addr_q <= addr_q + (compressed ? 31'd1 : 31'd2);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    err_q  <= err_d;
  end

  assign busy_o  = valid_q[Depth-1:1];
  assign count_o = count_q;

endmodule

// File: tb/tb_ibex_fetch_fifo_wide.sv
// Bench for ibex_fetch_fifo_wide: directed scenarios plus random
// traffic against a halfword-stream model, 32- and 64-bit buses.
module tb_ibex_fetch_fifo_wide;

  localparam int Depth = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0]       clr, in_v, in_e, rdy;
  logic [1:0][31:0] in_a;
  logic [1:0][63:0] in_d;
  logic [1:0]       o_v, o_e, o_p2;
  logic [1:0][31:0] o_a, o_d;
  logic [1:0][1:0]  busy, cnt;

  ibex_fetch_fifo_wide_if #(.BusBytes(4)) b4 ();
  ibex_fetch_fifo_wide_if #(.BusBytes(8)) b8 ();

  assign b4.in_valid_i  = in_v[0];
  assign b4.in_addr_i   = in_a[0];
  assign b4.in_rdata_i  = in_d[0][31:0];
  assign b4.in_err_i    = in_e[0];
  assign b4.out_ready_i = rdy[0];
  assign b8.in_valid_i  = in_v[1];
  assign b8.in_addr_i   = in_a[1];
  assign b8.in_rdata_i  = in_d[1];
  assign b8.in_err_i    = in_e[1];
  assign b8.out_ready_i = rdy[1];

  assign o_v[0]  = b4.out_valid_o;
  assign o_a[0]  = b4.out_addr_o;
  assign o_d[0]  = b4.out_rdata_o;
  assign o_e[0]  = b4.out_err_o;
  assign o_p2[0] = b4.out_err_plus2_o;
  assign o_v[1]  = b8.out_valid_o;
  assign o_a[1]  = b8.out_addr_o;
  assign o_d[1]  = b8.out_rdata_o;
  assign o_e[1]  = b8.out_err_o;
  assign o_p2[1] = b8.out_err_plus2_o;

  ibex_fetch_fifo_wide #(.NumReqs(2), .BusBytes(4)) dut4 (
    .clk_i  (clk),
    .rst_i  (rst),
    .clear_i(clr[0]),
    .busy_o (busy[0]),
    .count_o(cnt[0]),
    .bus    (b4.slave)
  );

  ibex_fetch_fifo_wide #(.NumReqs(2), .BusBytes(8)) dut8 (
    .clk_i  (clk),
    .rst_i  (rst),
    .clear_i(clr[1]),
    .busy_o (busy[1]),
    .count_o(cnt[1]),
    .bus    (b8.slave)
  );

  int errors = 0;
  int checks = 0;

  // Observer for pushes into a full FIFO with no pop.
  int illegal_seen = 0;
  always @(posedge clk) begin
    if (!rst && in_v[0] && !clr[0] && cnt[0] == 2'd3 &&
        !(o_v[0] && rdy[0])) illegal_seen++;
  end

  // Model: the fetch stream from pc onward as a halfword queue.
  logic [16:0] hq [2][64];
  int          hn [2];
  logic [31:0] pc [2];
  logic [16:0] st [72];
  int          ns;
  logic        e_v, e_l2, e_err, e_p2;
  logic [31:0] e_d;
  logic [1:0]  e_cnt, e_busy;

  function automatic int hwof(int k, logic [31:0] a);
    return int'((a >> 1) % (k != 0 ? 4 : 2));
  endfunction

  function automatic int beats(int k, logic [31:0] p, int n);
    int hp = (k != 0) ? 4 : 2;
    if (n == 0) return 0;
    return (hwof(k, p) + n + hp - 1) / hp;
  endfunction

  task automatic build(int k);
    int hp = (k != 0) ? 4 : 2;
    int j0;
    ns = hn[k];
    for (int j = 0; j < hn[k]; j++) st[j] = hq[k][j];
    if (in_v[k]) begin
      j0 = (hn[k] == 0) ? hwof(k, pc[k]) : 0;
      for (int j = j0; j < hp; j++) begin
        st[ns] = {in_e[k], in_d[k][16*j +: 16]};
        ns++;
      end
    end
  endtask

  task automatic model_eval(int k);
    build(k);
    e_l2   = (st[0][1:0] == 2'b11) || st[0][16];
    e_v    = ns >= (e_l2 ? 2 : 1);
    e_d    = {st[1][15:0], st[0][15:0]};
    e_err  = st[0][16] | (e_l2 & st[1][16]);
    e_p2   = e_l2 & st[1][16] & ~st[0][16];
    e_cnt  = 2'(beats(k, pc[k], hn[k]));
    e_busy = {e_cnt >= 2'd3, e_cnt >= 2'd2};
  endtask

  task automatic model_update(int k);
    int rem, rs, keep;
    if (clr[k]) begin
      hn[k] = 0;
      pc[k] = {in_a[k][31:1], 1'b0};
    end else begin
      model_eval(k);
      rem   = (rdy[k] && e_v) ? (e_l2 ? 2 : 1) : 0;
      pc[k] = pc[k] + 32'(2 * rem);
      rs    = (hn[k] > rem) ? hn[k] - rem : 0;
      keep  = ns;
      if (in_v[k] && beats(k, pc[k], rs) == Depth)
        keep = (hn[k] > rem) ? hn[k] : rem;
      hn[k] = (keep > rem) ? keep - rem : 0;
      for (int j = 0; j < hn[k]; j++) hq[k][j] = st[j + rem];
    end
  endtask

  task automatic idle();
    clr = '0; in_v = '0; in_e = '0; rdy = '0;
    in_a = '0; in_d = '0;
  endtask

  task automatic settle(int k);
    #1;
    model_eval(k);
  endtask

  task automatic tick(int k);
    @(posedge clk);
    model_update(k);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin hn[k] = 0; pc[k] = '0; end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_to(int k, logic [31:0] a);
    idle();
    clr[k] = 1'b1;
    in_a[k] = a;
    settle(k);
    tick(k);
    clr[k] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (o_v[0] !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", o_v[0]); end
    checks++; if (cnt[0] !== 2'd0) begin errors++;
      $display("FAIL reset_count: got %0d want 0", cnt[0]); end
    checks++; if (busy[0] !== 2'b00) begin errors++;
      $display("FAIL reset_busy: got %b want 00", busy[0]); end
    checks++; if (cnt[1] !== 2'd0 || o_v[1] !== 1'b0) begin errors++;
      $display("FAIL reset_wide: got cnt %0d v %b want 0 0", cnt[1], o_v[1]); end
    @(negedge clk);
    clear_to(0, 32'h80);
    settle(0);
    checks++; if (o_a[0] !== 32'h80) begin errors++;
      $display("FAIL clear_addr: got %h want 00000080", o_a[0]); end
  endtask

  task automatic test_compressed_bypass();
    clear_to(0, 32'h102);
    in_v[0] = 1'b1; in_d[0] = 64'h0001_4501; rdy[0] = 1'b1;
    settle(0);
    checks++; if (o_v[0] !== 1'b1 || o_d[0][15:0] !== 16'h0001) begin errors++;
      $display("FAIL cbyp_out: got v %b d %h want 1 0001", o_v[0], o_d[0][15:0]); end
    tick(0);
    idle();
    settle(0);
    checks++; if (o_a[0] !== 32'h104 || cnt[0] !== 2'd0) begin errors++;
      $display("FAIL cbyp_after: got a %h c %0d want 00000104 0", o_a[0], cnt[0]); end
  endtask

  task automatic test_spanning();
    clear_to(0, 32'h102);
    in_v[0] = 1'b1; in_d[0] = 64'h0013_abcd;
    settle(0);
    checks++; if (o_v[0] !== 1'b0) begin errors++;
      $display("FAIL span_wait: got %b want 0", o_v[0]); end
    tick(0);
    in_d[0] = 64'h1234_0000; in_e[0] = 1'b1; rdy[0] = 1'b1;
    settle(0);
    checks++; if (o_v[0] !== 1'b1 || o_d[0] !== 32'h0000_0013) begin errors++;
      $display("FAIL span_data: got v %b d %h want 1 00000013", o_v[0], o_d[0]); end
    checks++; if (o_e[0] !== 1'b1 || o_p2[0] !== 1'b1) begin errors++;
      $display("FAIL span_err: got %b%b want 11", o_e[0], o_p2[0]); end
    tick(0);
    idle();
    settle(0);
    checks++; if (o_a[0] !== 32'h106 || cnt[0] !== 2'd1) begin errors++;
      $display("FAIL span_after: got a %h c %0d want 00000106 1", o_a[0], cnt[0]); end
  endtask

  task automatic test_wide_span();
    clear_to(1, 32'h1006);
    in_v[1] = 1'b1; in_d[1] = 64'h0093_0000_0000_0000;
    settle(1);
    checks++; if (o_v[1] !== 1'b0) begin errors++;
      $display("FAIL wide_wait: got %b want 0", o_v[1]); end
    tick(1);
    in_d[1] = 64'h0000_0000_0000_00a0; rdy[1] = 1'b1;
    settle(1);
    checks++; if (o_v[1] !== 1'b1 || o_d[1] !== 32'h00a0_0093 ||
                  o_a[1] !== 32'h1006) begin errors++;
      $display("FAIL wide_out: got v %b d %h a %h want 1 00a00093 00001006",
               o_v[1], o_d[1], o_a[1]); end
    tick(1);
    idle();
    settle(1);
    checks++; if (o_a[1] !== 32'h100a || cnt[1] !== 2'd1) begin errors++;
      $display("FAIL wide_after: got a %h c %0d want 0000100a 1", o_a[1], cnt[1]); end
  endtask

  task automatic test_fill();
    logic [31:0] exp_d [3];
    int          ill0;
    exp_d[0] = 32'h0000_0013;
    exp_d[1] = 32'h0010_0093;
    exp_d[2] = 32'h0020_0113;
    clear_to(0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      in_v[0] = 1'b1; in_d[0] = {32'h0, exp_d[i]};
      settle(0);
      tick(0);
    end
    in_v[0] = 1'b0;
    settle(0);
    checks++; if (cnt[0] !== 2'd3 || busy[0] !== 2'b11) begin errors++;
      $display("FAIL fill_count: got c %0d b %b want 3 11", cnt[0], busy[0]); end
    ill0 = illegal_seen;
    in_v[0] = 1'b1; in_d[0] = 64'hdead_beef;
    settle(0);
    tick(0);
    in_v[0] = 1'b0;
    settle(0);
    checks++; if (illegal_seen - ill0 !== 1) begin errors++;
      $display("FAIL fill_illegal: got %0d want 1", illegal_seen - ill0); end
    checks++; if (cnt[0] !== 2'd3 || o_d[0] !== exp_d[0]) begin errors++;
      $display("FAIL fill_kept: got c %0d d %h want 3 %h", cnt[0], o_d[0], exp_d[0]); end
    rdy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle(0);
      checks++; if (o_v[0] !== 1'b1 || o_d[0] !== exp_d[i]) begin errors++;
        $display("FAIL drain_%0d: got v %b d %h want 1 %h", i, o_v[0], o_d[0], exp_d[i]); end
      tick(0);
    end
    settle(0);
    checks++; if (o_v[0] !== 1'b0 || cnt[0] !== 2'd0) begin errors++;
      $display("FAIL drain_empty: got v %b c %0d want 0 0", o_v[0], cnt[0]); end
    rdy[0] = 1'b0;
  endtask

  task automatic test_clear_drop();
    clear_to(0, 32'h40);
    for (int i = 0; i < 2; i++) begin
      in_v[0] = 1'b1; in_d[0] = {32'h0, $urandom};
      settle(0);
      tick(0);
    end
    clr[0] = 1'b1; in_a[0] = 32'h200; in_d[0] = {32'h0, $urandom};
    settle(0);
    tick(0);
    idle();
    settle(0);
    checks++; if (cnt[0] !== 2'd0 || o_a[0] !== 32'h200 || o_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_drop: got c %0d a %h v %b want 0 00000200 0",
               cnt[0], o_a[0], o_v[0]); end
  endtask

  task automatic test_wrap();
    clear_to(0, 32'hffff_fffe);
    in_v[0] = 1'b1; in_d[0] = 64'h0001_0000; rdy[0] = 1'b1;
    settle(0);
    checks++; if (o_v[0] !== 1'b1 || o_a[0] !== 32'hffff_fffe) begin errors++;
      $display("FAIL wrap_pre: got v %b a %h want 1 fffffffe", o_v[0], o_a[0]); end
    tick(0);
    idle();
    settle(0);
    checks++; if (o_a[0] !== 32'h0) begin errors++;
      $display("FAIL wrap_post: got %h want 00000000", o_a[0]); end
  endtask

  task automatic test_random(int k, int n);
    logic [63:0] d;
    clear_to(k, $urandom & 32'hffff_fffe);
    for (int c = 0; c < n; c++) begin
      d = {$urandom, $urandom};
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 1) == 1) d[16*j +: 2] = 2'b11;
      in_v[k] = ($urandom_range(0, 3) != 0);
      in_d[k] = d;
      in_e[k] = ($urandom_range(0, 15) == 0);
      rdy[k]  = ($urandom_range(0, 2) != 0);
      clr[k]  = ($urandom_range(0, 31) == 0);
      in_a[k] = ($urandom_range(0, 3) == 0) ? (32'hffff_fff0 | $urandom)
                                            : $urandom;
      settle(k);
      checks++; if (o_v[k] !== e_v) begin errors++;
        $display("FAIL rnd%0d_valid c%0d: got %b want %b", k, c, o_v[k], e_v); end
      checks++; if (o_a[k] !== pc[k]) begin errors++;
        $display("FAIL rnd%0d_addr c%0d: got %h want %h", k, c, o_a[k], pc[k]); end
      checks++; if (cnt[k] !== e_cnt || busy[k] !== e_busy) begin errors++;
        $display("FAIL rnd%0d_count c%0d: got %0d/%b want %0d/%b",
                 k, c, cnt[k], busy[k], e_cnt, e_busy); end
      if (e_v) begin
        checks++; if (o_d[k][15:0] !== e_d[15:0] ||
                      (e_l2 && o_d[k][31:16] !== e_d[31:16])) begin errors++;
          $display("FAIL rnd%0d_data c%0d: got %h want %h", k, c, o_d[k], e_d); end
        checks++; if (o_e[k] !== e_err || o_p2[k] !== e_p2) begin errors++;
          $display("FAIL rnd%0d_err c%0d: got %b%b want %b%b",
                   k, c, o_e[k], o_p2[k], e_err, e_p2); end
      end
      tick(k);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < 72; i++) st[i] = '0;
    for (int k = 0; k < 2; k++) begin
      hn[k] = 0;
      pc[k] = '0;
      for (int i = 0; i < 64; i++) hq[k][i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_compressed_bypass();
    test_spanning();
    test_wide_span();
    test_fill();
    test_clear_drop();
    test_wrap();
    test_random(0, 600);
    test_random(1, 600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_fetch_fifo_wide.md
Name: ibex_fetch_fifo_wide

Overview:
- Parametrised next-generation instruction fetch FIFO. Buffers BusBytes-wide memory fetch beats from the prefetch buffer and realigns them into 32-bit (or compressed 16-bit) instructions for the IF stage.
- Supports 32-bit and 64-bit instruction buses, so an instruction can start at any halfword of an entry and span two entries.
- Adds an occupancy count output and full-push protection. Sits between the prefetch buffer and the IF-stage compressed decoder.

Parameters:
- NumReqs, 2: maximum outstanding bus requests. Depth = NumReqs+1 entries.
- BusBytes, 4: fetch beat width in bytes. Legal values are 4 or 8; any other value is an elaboration error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  flush; the next fetch address is taken from in_addr_i.
- busy_o  out  NumReqs  valid flags of the top NumReqs entries.
- count_o  out  $clog2(Depth+1)  number of valid entries.
- in_valid_i  in  1  incoming fetch beat valid.
- in_addr_i  in  32  branch target address, sampled when clear_i=1.
- in_rdata_i  in  BusBytes*8  fetch beat data, aligned to BusBytes.
- in_err_i  in  1  bus error for the beat.
- out_valid_o  out  1  instruction available.
- out_ready_i  in  1  consumer accepts the instruction.
- out_addr_o  out  32  PC of the output instruction; bit 0 is always 0.
- out_rdata_o  out  32  instruction; the upper half is don't-care when compressed.
- out_err_o  out  1  instruction is affected by a fetch error.
- out_err_plus2_o  out  1  error lies only in the second halfword of an entry-spanning 32-bit instruction.

Behaviour:
- Reset (rst_i=1 at a clock edge): all valid flags 0, address register 0.
  - Resulting outputs: count_o=0, busy_o=0, out_valid_o=0 unless in_valid_i bypasses.
  - Data and err flops are not reset.
- Storage: Depth entries of {data, err}. Entry 0 is the head. Entries fill lowest-free-first and shift down by one on pop.
- Halfword pointer: hw = addr_q[log2(BusBytes)-1:1]; it selects the starting halfword within the head.
- Sources and bypass:
  - Head source (H) = entry0 if valid, else in_rdata_i/in_err_i.
  - Next source (N) = entry1 if valid, else in_rdata_i; N is used only when entry0 is valid.
- Halfword extraction:
  - h0 = H[hw].
  - h1 = H[hw+1] when hw < BusBytes/2-1; otherwise N[0] (spanning case).
- Compressed: compressed = (h0[1:0] != 2'b11) & ~err_H.
- Valid:
  - Compressed or non-spanning instruction: out_valid_o = valid_q[0] | in_valid_i.
  - Spanning 32-bit instruction: out_valid_o = valid_q[1] | (valid_q[0] & in_valid_i).
- Errors:
  - out_err_o = err_H | (spanning & ~compressed & err_N).
  - out_err_plus2_o = spanning & ~compressed & err_N & ~err_H; forced 0 when not spanning.
- Transfer: occurs when out_valid_o & out_ready_i.
  - addr_q advances by 2 (compressed) or 4.
  - The head entry pops when the instruction consumes its last halfword: hw = last, or hw = last-1 and not compressed, or any spanning instruction.
- Push: when in_valid_i & ~clear_i, the beat is written to the lowest free entry after a same-cycle pop.
  - A beat consumed entirely through bypass in the same cycle is not stored; a bypassed beat that is only partly consumed is stored.
  - Push with all Depth entries valid and no pop is illegal: the beat is dropped and no entry is overwritten. The verification bench flags it with an assertion.
- Clear: all valid flags go to 0 the next cycle, addr_q <= in_addr_i[31:1]. A same-cycle in_valid_i beat is discarded. out_valid_o is not suppressed combinationally; the consumer ignores it when clear_i=1. Clear overrides a same-cycle transfer.
- Address wrap: addr_q wraps modulo 2^32 (0xFFFFFFFE + 2 -> 0x00000000).
- Counters: count_o = popcount(valid_q); registered, zero-latency relative to the state.
- Latency: zero-cycle bypass from in_valid_i to out_valid_o when the FIFO is empty.

Test Plan:
- Reset with in_valid_i=0 -> out_valid_o=0, count_o=0, busy_o=0. Then clear_i with in_addr_i=0x80 -> out_addr_o=0x80 next cycle.
- BusBytes=4: clear to 0x102, beat 0x0001_4501 (compressed 0x0001 at upper halfword) -> out_rdata_o[15:0]=0x0001, out_valid_o=1. After transfer, out_addr_o=0x104 and count_o=0.
- BusBytes=4: clear to 0x102, beat0 0x0013_xxxx, beat1 0xxxxx_0000 -> out_rdata_o=0x0000_0013 once beat1 arrives. With beat1 err=1 and beat0 err=0 -> out_err_o=1, out_err_plus2_o=1.
- BusBytes=8: clear to 0x1006, two beats, instruction 0x00A0_0093 spanning -> out_rdata_o=0x00A00093, out_addr_o=0x1006. After transfer, out_addr_o=0x100A and one entry popped.
- Fill with NumReqs=2 and out_ready_i=0: three beats -> count_o=3, busy_o=2'b11. A fourth push with no pop -> assertion fires and entries are unchanged.
- Simultaneous clear_i and in_valid_i with 2 entries valid -> count_o=0 next cycle, out_addr_o=new target, incoming beat dropped.
